// File: rtl/sched_pkg.sv
// sched_pkg: shared types and constants for the process scheduler.
//   slot_state_e : per-slot process state held in the process table
//   fsm_state_e  : scheduler control FSM states
//   event_e      : latched context-switch cause
//   OS_PC_DEFAULT: PC of the OS idle loop
package sched_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_READY   = 2'd1,
    SLOT_RUNNING = 2'd2,
    SLOT_BLOCKED = 2'd3
  } slot_state_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_SAVE     = 3'd2,
    ST_SELECT   = 3'd3,
    ST_DISPATCH = 3'd4
  } fsm_state_e;

  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_END     = 2'd1,
    EV_IO      = 2'd2,
    EV_QUANTUM = 2'd3
  } event_e;

  localparam logic [31:0] OS_PC_DEFAULT = 32'd0;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin find-first.
//   i_mask  : candidate bitmap (one bit per slot)
//   i_start : index searched first; the search wraps modulo N
//   o_found : at least one candidate bit is set
//   o_idx   : first set index at or after i_start (wrapping)
// N must be a power of two so the index addition wraps naturally.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_mask,
  input  logic [$clog2(N)-1:0] i_start,
  output logic                 o_found,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_cand;

  // Walk from the farthest candidate towards i_start so the nearest hit
  // is the last one written and therefore wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = i_start + IW'(k);
      if (i_mask[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// process_scheduler: round-robin process scheduler with a small process table.
// Reacts to quantum expiry, I/O request and process end from the running
// process, saves its resume PC, picks the next READY slot and issues a
// one-cycle PC-load request to fetch.
// Ports:
//   clock, reset (async, active-low)
//   create_valid/create_pc -> create_ack (same-cycle pulse), create_full (registered)
//   quantum_expired, io_request, proc_end, event_pc : events from the running process
//   io_done[NPROC] : per-slot I/O completion pulses
//   pc_load, next_pc, current_pid, running : dispatch interface to fetch
//   dbg_state : current control FSM state
// Build option: SCHED_IO_BLOCK_EN -- when defined an I/O request blocks the
// slot until its io_done pulse; when undefined I/O behaves like quantum expiry.
module process_scheduler import sched_pkg::*; #(
  parameter int              NPROC = 4,
  parameter int              PC_W  = 32,
  parameter logic [PC_W-1:0] OS_PC = PC_W'(OS_PC_DEFAULT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     create_valid,
  input  logic [PC_W-1:0]          create_pc,
  output logic                     create_ack,
  output logic                     create_full,
  input  logic                     quantum_expired,
  input  logic                     io_request,
  input  logic                     proc_end,
  input  logic [PC_W-1:0]          event_pc,
  input  logic [NPROC-1:0]         io_done,
  output logic                     pc_load,
  output logic [PC_W-1:0]          next_pc,
  output logic [$clog2(NPROC)-1:0] current_pid,
  output logic                     running,
  output logic [2:0]               dbg_state
);

  localparam int PID_W = $clog2(NPROC);

  slot_state_e     r_slot_state [NPROC];
  logic [PC_W-1:0] r_slot_pc    [NPROC];
  fsm_state_e      r_state, w_state_nxt;
  event_e          r_event, w_event;
  logic [PC_W-1:0] r_event_pc;
  logic [PC_W-1:0] r_next_pc;
  logic [PID_W-1:0] r_current_pid;
  logic            r_running;
  logic            r_create_full;

  logic [NPROC-1:0] w_ready_mask, w_free_mask, w_unblock;
  logic             w_ready_found, w_free_found, w_create_accept;
  logic [PID_W-1:0] w_ready_idx, w_free_idx;

  always_comb begin
    for (int i = 0; i < NPROC; i++) begin
      w_ready_mask[i] = (r_slot_state[i] == SLOT_READY);
      w_free_mask[i]  = (r_slot_state[i] == SLOT_FREE);
    end
  end

  // Search starts after the current slot, so the preempted slot comes last.
  rr_picker #(.N(NPROC)) u_ready_pick (
    .i_mask  (w_ready_mask),
    .i_start (r_current_pid + PID_W'(1)),
    .o_found (w_ready_found),
    .o_idx   (w_ready_idx)
  );

  rr_picker #(.N(NPROC)) u_free_pick (
    .i_mask  (w_free_mask),
    .i_start ('0),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  assign w_create_accept = create_valid && (r_state != ST_SAVE) && w_free_found;

  // Highest-priority event wins; the rest of that cycle's events are dropped.
  always_comb begin
    w_event = EV_NONE;
    if (proc_end)
      w_event = EV_END;
    else if (io_request)
`ifdef SCHED_IO_BLOCK_EN
      w_event = EV_IO;
`else
      w_event = EV_QUANTUM;
`endif
    else if (quantum_expired)
      w_event = EV_QUANTUM;
  end

`ifdef SCHED_IO_BLOCK_EN
  // An io_done aimed at the slot SAVE is writing is parked for one cycle so
  // the SAVE write lands first.
  logic [NPROC-1:0] r_io_pend;
  assign w_unblock = io_done | r_io_pend;
`else
  logic w_unused_io_done;
  assign w_unused_io_done = ^io_done;
  assign w_unblock        = '0;
`endif

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; the create accepted this cycle counts as READY so a
  // freshly created process dispatches two cycles after its ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (|w_ready_mask || w_create_accept) w_state_nxt = ST_SELECT;
      ST_RUN:      if (w_event != EV_NONE) w_state_nxt = ST_SAVE;
      ST_SAVE:     w_state_nxt = ST_SELECT;
      ST_SELECT:   w_state_nxt = ST_DISPATCH;
      ST_DISPATCH: w_state_nxt = r_running ? ST_RUN : ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Dispatch registers and process table
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_event       <= EV_NONE;
      r_event_pc    <= '0;
      r_next_pc     <= OS_PC;
      r_current_pid <= '0;
      r_running     <= 1'b0;
      r_create_full <= 1'b0;
`ifdef SCHED_IO_BLOCK_EN
      r_io_pend     <= '0;
`endif
      for (int i = 0; i < NPROC; i++) begin
        r_slot_state[i] <= SLOT_FREE;
        r_slot_pc[i]    <= '0;
      end
    end else begin
      r_create_full <= ~w_free_found;
      if (r_state == ST_RUN && w_event != EV_NONE) begin
        r_event    <= w_event;
        r_event_pc <= event_pc;
      end
      // The dispatch decision is committed at the SELECT edge so next_pc is
      // already valid while pc_load is high in DISPATCH.
      if (r_state == ST_SELECT) begin
        if (w_ready_found) begin
          r_next_pc     <= r_slot_pc[w_ready_idx];
          r_current_pid <= w_ready_idx;
          r_running     <= 1'b1;
        end else begin
          r_next_pc <= OS_PC;
          r_running <= 1'b0;
        end
      end
      for (int i = 0; i < NPROC; i++) begin
`ifdef SCHED_IO_BLOCK_EN
        r_io_pend[i] <= io_done[i] && (r_state == ST_SAVE) && (PID_W'(i) == r_current_pid);
`endif
        if (r_state == ST_SAVE && PID_W'(i) == r_current_pid) begin
          case (r_event)
            EV_END: r_slot_state[i] <= SLOT_FREE;
            EV_IO: begin
              r_slot_state[i] <= SLOT_BLOCKED;
              r_slot_pc[i]    <= r_event_pc;
            end
            EV_QUANTUM: begin
              r_slot_state[i] <= SLOT_READY;
              r_slot_pc[i]    <= r_event_pc;
            end
            default: ;
          endcase
        end else if (w_unblock[i] && r_slot_state[i] == SLOT_BLOCKED) begin
          r_slot_state[i] <= SLOT_READY;
        end else if (r_state == ST_SELECT && w_ready_found && w_ready_idx == PID_W'(i)) begin
          r_slot_state[i] <= SLOT_RUNNING;
        end else if (w_create_accept && w_free_idx == PID_W'(i)) begin
          r_slot_state[i] <= SLOT_READY;
          r_slot_pc[i]    <= create_pc;
        end
      end
    end
  end

  assign create_ack  = w_create_accept;
  assign create_full = r_create_full;
  assign pc_load     = (r_state == ST_DISPATCH);
  assign next_pc     = r_next_pc;
  assign current_pid = r_current_pid;
  assign running     = r_running;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_process_scheduler.sv
// tb_process_scheduler: self-checking bench for process_scheduler.
// Expected dispatches are produced by a slot-table model and checked by the
// pc_load monitor from an expected queue; tasks check acks, timing and levels.
module tb_process_scheduler;

  localparam int NPROC = 4;
  localparam int PC_W  = 32;
  localparam int PID_W = $clog2(NPROC);
  localparam int EW    = 1 + PID_W + PC_W;
  localparam logic [PC_W-1:0] OS_PC = 32'h0000_0F00;
  localparam int M_FREE = 0, M_READY = 1, M_RUN = 2, M_BLOCKED = 3;

  logic              clock = 1'b0, reset = 1'b0;
  logic              create_valid = 1'b0;
  logic [PC_W-1:0]   create_pc = '0, event_pc = '0;
  logic              quantum_expired = 1'b0, io_request = 1'b0, proc_end = 1'b0;
  logic [NPROC-1:0]  io_done = '0;
  logic              create_ack, create_full, pc_load, running;
  logic [PC_W-1:0]   next_pc;
  logic [PID_W-1:0]  current_pid;
  logic [2:0]        dbg_state;

  int total = 0, bad = 0, cyc_cnt = 0, last_load_cyc = -1;
  logic [EW-1:0] exp_q[$];

  // model: one entry per slot
  int              m_st [NPROC];
  logic [PC_W-1:0] m_pc [NPROC];
  int              m_cur;
  bit              m_run;
  logic [PC_W-1:0] m_next;

  process_scheduler #(.NPROC(NPROC), .PC_W(PC_W), .OS_PC(OS_PC)) dut (
    .clock(clock), .reset(reset),
    .create_valid(create_valid), .create_pc(create_pc),
    .create_ack(create_ack), .create_full(create_full),
    .quantum_expired(quantum_expired), .io_request(io_request),
    .proc_end(proc_end), .event_pc(event_pc), .io_done(io_done),
    .pc_load(pc_load), .next_pc(next_pc), .current_pid(current_pid),
    .running(running), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: every pc_load must match the oldest expected dispatch
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (reset && pc_load) begin
      last_load_cyc = cyc_cnt;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pc_load: got pc=%0h pid=%0d running=%0b, required no load",
                 next_pc, current_pid, running);
      end else begin
        e = exp_q.pop_front();
        if ({running, current_pid, next_pc} !== e) begin
          bad++;
          $display("FAIL dispatch: got running=%0b pid=%0d pc=%0h, required running=%0b pid=%0d pc=%0h",
                   running, current_pid, next_pc, e[EW-1], e[PC_W +: PID_W], e[PC_W-1:0]);
        end
      end
    end
  end

  // ---------------- model ----------------
  function automatic void m_reset();
    for (int i = 0; i < NPROC; i++) begin m_st[i] = M_FREE; m_pc[i] = '0; end
    m_cur = 0; m_run = 1'b0; m_next = OS_PC;
    exp_q.delete();
  endfunction

  function automatic int m_free_slot();
    for (int i = 0; i < NPROC; i++) if (m_st[i] == M_FREE) return i;
    return -1;
  endfunction

  function automatic void m_create(input logic [PC_W-1:0] pc);
    int s = m_free_slot();
    if (s >= 0) begin m_st[s] = M_READY; m_pc[s] = pc; end
  endfunction

  function automatic void m_select();
    int f = -1;
    for (int k = 1; k <= NPROC; k++)
      if (f < 0 && m_st[(m_cur + k) % NPROC] == M_READY) f = (m_cur + k) % NPROC;
    if (f >= 0) begin
      m_st[f] = M_RUN; m_cur = f; m_run = 1'b1; m_next = m_pc[f];
    end else begin
      m_run = 1'b0; m_next = OS_PC;
    end
    exp_q.push_back({m_run, PID_W'(m_cur), m_next});
  endfunction

  function automatic void m_event(input bit pe, input bit io, input bit q, input logic [PC_W-1:0] epc);
    if (pe) m_st[m_cur] = M_FREE;
`ifdef SCHED_IO_BLOCK_EN
    else if (io) begin m_st[m_cur] = M_BLOCKED; m_pc[m_cur] = epc; end
`else
    else if (io) begin m_st[m_cur] = M_READY; m_pc[m_cur] = epc; end
`endif
    else if (q) begin m_st[m_cur] = M_READY; m_pc[m_cur] = epc; end
    m_select();
  endfunction

  function automatic bit m_unblock(input logic [NPROC-1:0] mask);
    bit any = 1'b0;
    for (int i = 0; i < NPROC; i++) begin
`ifdef SCHED_IO_BLOCK_EN
      if (mask[i] && m_st[i] == M_BLOCKED) m_st[i] = M_READY;
`endif
      if (m_st[i] == M_READY) any = 1'b1;
    end
    return any;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; create_valid = 0; proc_end = 0; io_request = 0;
    quantum_expired = 0; io_done = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    m_reset();
  endtask

  task automatic drive_create(input logic [PC_W-1:0] pc, output bit ack);
    create_valid = 1'b1; create_pc = pc;
    @(negedge clock); ack = create_ack;
    @(posedge clock); #1;
    create_valid = 1'b0; create_pc = '0;
  endtask

  task automatic drive_event(input bit pe, input bit io, input bit q,
                             input logic [PC_W-1:0] epc, output int t);
    t = cyc_cnt;
    proc_end = pe; io_request = io; quantum_expired = q; event_pc = epc;
    @(posedge clock); #1;
    proc_end = 0; io_request = 0; quantum_expired = 0; event_pc = ~epc;
  endtask

  task automatic drive_io_done(input logic [NPROC-1:0] mask);
    io_done = mask;
    @(posedge clock); #1;
    io_done = '0;
  endtask

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 24 && !ok; n++) begin
      @(negedge clock);
      if (pc_load === 1'b1) ok = 1'b1;
    end
    @(posedge clock); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) cyc();
    total++; if (pc_load !== 1'b0) begin bad++; $display("FAIL rst_pc_load: got %0b required 0", pc_load); end
    total++; if (next_pc !== OS_PC) begin bad++; $display("FAIL rst_next_pc: got %0h required %0h", next_pc, OS_PC); end
    total++; if (current_pid !== '0) begin bad++; $display("FAIL rst_pid: got %0d required 0", current_pid); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_running: got %0b required 0", running); end
    total++; if (create_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %0b required 0", create_ack); end
    total++; if (create_full !== 1'b0) begin bad++; $display("FAIL rst_full: got %0b required 0", create_full); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d required 0", dbg_state); end
    reset = 1'b1;
    m_reset();
    repeat (3) cyc();
    total++; if (running !== 1'b0 || next_pc !== OS_PC) begin
      bad++; $display("FAIL idle_empty: got running=%0b pc=%0h required 0/%0h", running, next_pc, OS_PC);
    end
  endtask

  task automatic test_create_dispatch();
    bit a0, a1, ok; int t;
    do_reset();
    t = cyc_cnt;
    drive_create(32'd400, a0); m_create(32'd400); m_select();
    drive_create(32'd600, a1); m_create(32'd600);
    total++; if (a0 !== 1'b1 || a1 !== 1'b1) begin bad++; $display("FAIL create_acks: got %0b%0b required 11", a0, a1); end
    wait_load(ok);
    total++; if (!ok || last_load_cyc != t + 2) begin
      bad++; $display("FAIL startup_latency: got cycle %0d required %0d", last_load_cyc - t, 2);
    end
  endtask

  task automatic test_quantum();
    bit ok; int t;
    test_create_dispatch();
    drive_event(0, 0, 1, 32'd405, t); m_event(0, 0, 1, 32'd405);
    wait_load(ok);
    total++; if (!ok || last_load_cyc != t + 3) begin
      bad++; $display("FAIL quantum_latency: got %0d required 3", last_load_cyc - t);
    end
    // slot 0 must come back with the saved PC 405
    drive_event(0, 0, 1, 32'd605, t); m_event(0, 0, 1, 32'd605);
    wait_load(ok);
    total++; if (!ok) begin bad++; $display("FAIL quantum_resume: got no pc_load required load"); end
  endtask

  task automatic test_io();
    bit a, ok; int t;
    do_reset();
    drive_create(32'd400, a); m_create(32'd400); m_select();
    wait_load(ok);
    drive_event(0, 1, 0, 32'd410, t); m_event(0, 1, 0, 32'd410);
    wait_load(ok);
    total++; if (!ok || last_load_cyc != t + 3) begin
      bad++; $display("FAIL io_latency: got %0d required 3", last_load_cyc - t);
    end
`ifdef SCHED_IO_BLOCK_EN
    total++; if (running !== 1'b0) begin bad++; $display("FAIL io_idle: got running=%0b required 0", running); end
    drive_io_done(4'b0001); void'(m_unblock(4'b0001)); m_select();
    wait_load(ok);
    total++; if (!ok) begin bad++; $display("FAIL io_resume: got no pc_load required load"); end
    // io_done lands while SAVE writes the same slot: OS first, then resume
    drive_event(0, 1, 0, 32'd420, t); m_event(0, 1, 0, 32'd420);
    drive_io_done(4'b0001);
    wait_load(ok);
    void'(m_unblock(4'b0001)); m_select();
    wait_load(ok);
    total++; if (!ok) begin bad++; $display("FAIL io_collide: got no pc_load required load"); end
`endif
  endtask

  task automatic test_end_priority();
    bit a, ok; int t;
    test_create_dispatch();
    drive_event(1, 0, 1, 32'd999, t); m_event(1, 0, 1, 32'd999);
    wait_load(ok);
    total++; if (!ok) begin bad++; $display("FAIL end_dispatch: got no pc_load required load"); end
    drive_create(32'd300, a); m_create(32'd300);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL end_reuse_ack: got %0b required 1", a); end
    cyc();
    drive_event(0, 0, 1, 32'd222, t); m_event(0, 0, 1, 32'd222);
    wait_load(ok);
    total++; if (!ok) begin bad++; $display("FAIL end_reuse_dispatch: got no pc_load required load"); end
  endtask

  task automatic test_full();
    bit a, ok; int t;
    do_reset();
    drive_create(32'd1000, a); m_create(32'd1000); m_select();
    wait_load(ok);
    for (int i = 1; i < NPROC; i++) begin
      drive_create(32'd1000 + 32'(i), a); m_create(32'd1000 + 32'(i));
      total++; if (a !== 1'b1) begin bad++; $display("FAIL fill_ack%0d: got %0b required 1", i, a); end
    end
    cyc();
    total++; if (create_full !== 1'b1) begin bad++; $display("FAIL full_set: got %0b required 1", create_full); end
    drive_create(32'd2000, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL full_noack: got %0b required 0", a); end
    drive_event(1, 0, 0, 32'd0, t); m_event(1, 0, 0, 32'd0);
    wait_load(ok);
    total++; if (create_full !== 1'b0) begin bad++; $display("FAIL full_clear: got %0b required 0", create_full); end
    drive_create(32'd2000, a); m_create(32'd2000);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL full_reack: got %0b required 1", a); end
    cyc();
    total++; if (create_full !== 1'b1) begin bad++; $display("FAIL full_again: got %0b required 1", create_full); end
  endtask

  task automatic test_reset_mid();
    bit a, ok; int t;
    test_create_dispatch();
    drive_event(0, 0, 1, 32'd777, t);   // no dispatch expected: aborted
    cyc();                              // now in SELECT
    reset = 1'b0;
    #1;
    total++; if ({pc_load, running, current_pid, next_pc, create_full} !== {1'b0, 1'b0, PID_W'(0), OS_PC, 1'b0}) begin
      bad++; $display("FAIL mid_reset_outputs: got load=%0b run=%0b pid=%0d pc=%0h full=%0b required 0/0/0/%0h/0",
                      pc_load, running, current_pid, next_pc, create_full, OS_PC);
    end
    repeat (2) cyc();
    reset = 1'b1;
    m_reset();
    repeat (6) cyc();                   // an emptied table never dispatches
    total++; if (running !== 1'b0 || dbg_state !== 3'd0) begin
      bad++; $display("FAIL mid_reset_idle: got running=%0b state=%0d required 0/0", running, dbg_state);
    end
    drive_create(32'd700, a); m_create(32'd700); m_select();
    wait_load(ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_reset_recover: got no pc_load required load"); end
  endtask

  task automatic test_random();
    bit ok, a, ea, pe, io, q, any; int t, act;
    logic [PC_W-1:0] pc; logic [NPROC-1:0] mask;
    do_reset();
    for (int it = 0; it < 300; it++) begin
      total++; if (create_full !== (m_free_slot() < 0)) begin
        bad++; $display("FAIL rnd_full it=%0d: got %0b required %0b", it, create_full, m_free_slot() < 0);
      end
      total++; if ({running, current_pid, next_pc} !== {m_run, PID_W'(m_cur), m_next}) begin
        bad++; $display("FAIL rnd_hold it=%0d: got run=%0b pid=%0d pc=%0h required run=%0b pid=%0d pc=%0h",
                        it, running, current_pid, next_pc, m_run, m_cur, m_next);
      end
      act = $urandom_range(0, 9);
      pc  = $urandom;
      {pe, io, q} = 3'($urandom_range(1, 7));
      if (m_run && act < 4) begin
        drive_event(pe, io, q, pc, t); m_event(pe, io, q, pc);
        wait_load(ok);
        total++; if (!ok || last_load_cyc != t + 3) begin
          bad++; $display("FAIL rnd_event it=%0d: got latency %0d required 3", it, last_load_cyc - t);
        end
      end else if (act < 7) begin
        t = cyc_cnt; ea = (m_free_slot() >= 0);
        drive_create(pc, a);
        total++; if (a !== ea) begin bad++; $display("FAIL rnd_ack it=%0d: got %0b required %0b", it, a, ea); end
        if (ea) m_create(pc);
        if (ea && !m_run) begin
          m_select(); wait_load(ok);
          total++; if (!ok || last_load_cyc != t + 2) begin
            bad++; $display("FAIL rnd_start it=%0d: got latency %0d required 2", it, last_load_cyc - t);
          end
        end else cyc();
      end else if (act < 9) begin
        mask = NPROC'($urandom);
        drive_io_done(mask); any = m_unblock(mask);
        if (!m_run && any) begin
          m_select(); wait_load(ok);
          total++; if (!ok) begin bad++; $display("FAIL rnd_unblock it=%0d: got no pc_load required load", it); end
        end else cyc();
      end else begin
        if (!m_run) drive_event(pe, io, q, pc, t);   // ignored outside RUN
        cyc();
      end
    end
  endtask

  initial begin
    test_reset();
    test_create_dispatch();
    test_quantum();
    test_io();
    test_end_priority();
    test_full();
    test_reset_mid();
    test_random();
    repeat (4) cyc();
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL pending_dispatch: got %0d outstanding required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
